// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: converter FSM
// encoding, display geometry and active-low segment patterns (gfedcba).
package ssd_pkg;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 13;
    localparam int BCD_W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Non-decimal nibbles cannot occur from a 13-bit source; show a dash
    // so a corrupted value is visible rather than silently wrong.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. Runs continuously: one IDLE cycle
// captures the input, 13 SHIFT cycles convert, one LATCH cycle publishes
// the result, giving a fixed 15-cycle period.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] value,
    output logic [BCD_W-1:0] bcd_out,
    output logic             done
);

    conv_state_t      state;
    conv_state_t      state_next;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_acc;
    logic [3:0]       iter;

    // Add 3 to every nibble >= 5 so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            nib = b[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            r[4*i +: 4] = nib;
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE and LATCH last one cycle, SHIFT runs 13 times.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = SHIFT;
            SHIFT:   state_next = (iter == 4'd12) ? LATCH : SHIFT;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Work registers, published result and the done pulse that marks it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_sr  <= '0;
            bcd_acc <= '0;
            iter    <= '0;
            bcd_out <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == LATCH);
            case (state)
                IDLE: begin
                    bin_sr  <= value;
                    bcd_acc <= '0;
                    iter    <= '0;
                end
                SHIFT: begin
                    {bcd_acc, bin_sr} <= {bcd_adjust(bcd_acc), bin_sr} << 1;
                    iter              <= iter + 4'd1;
                end
                LATCH: begin
                    bcd_out <= bcd_acc;
                end
                default: begin
                    bin_sr <= bin_sr;
                end
            endcase
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode seven-segment driver for the Nexys A7. Converts
// the 13-bit debug value to BCD and scans one digit at a time, optionally
// blanking leading zeros. Anodes, cathodes and dp are all active-low.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_CNT = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [15:0] bcd_out,
    output logic        done,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;

    logic [CNT_W-1:0]  refresh_cnt;
    logic [1:0]        digit_idx;
    logic [DIGITS-1:0] blank_mask;
    logic [3:0]        digit_nib;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .bcd_out (bcd_out),
        .done    (done)
    );

    // Refresh timer: each digit stays lit for REFRESH_CNT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == CNT_W'(REFRESH_CNT - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    // Leading-zero mask: a digit blanks when it and every higher digit are
    // zero; the units digit always shows.
    always_comb begin
        logic higher_zero;
        blank_mask  = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero && (bcd_out[4*i +: 4] == 4'd0);
            blank_mask[i] = (BLANK_LZ != 0) && higher_zero;
        end
    end

    assign digit_nib = bcd_out[4*digit_idx +: 4];
    assign dp        = 1'b1;

    // Registered pin drive for the currently selected digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode   <= 4'b1111;
            cathode <= SEG_OFF;
        end else if (blank_mask[digit_idx]) begin
            anode   <= 4'b1111;
            cathode <= SEG_OFF;
        end else begin
            anode   <= ~(4'b0001 << digit_idx);
            cathode <= seg_decode(digit_nib);
        end
    end

endmodule
